// File: rtl/mcs_io_responder.sv
// ---------------------------------------------------------------------------
// mcs_io_responder
//
// Target side of the MicroBlaze MCS IO bus. Each access is accepted in IDLE,
// optionally held for WAIT_CYCLES clocks, then answered with a one-cycle
// IO_Ready pulse. The register bank holds the LED register, a synchronized copy
// of the DIP switches, a scratch word, a free-running cycle counter and
// (optionally) a switch-change interrupt.
//
// Optional feature macro: MCS_IO_IRQ_EN
//   defined     : switch change detect, IRQ_STAT (0x10), IRQ_EN (0x14), irq
//   not defined : 0x10/0x14 read 0 and ignore writes, irq held 0
//
// Parameters
//   WAIT_CYCLES  extra cycles between accept and IO_Ready (0..15)
//   LED_W        width of the LED register / led output (1..32)
//   SW_W         width of the dip_sw input (1..32)
//
// Ports
//   Clk              system clock
//   Reset            synchronous reset, active low
//   IO_Addr_Strobe   one-cycle transaction start
//   IO_Read_Strobe   read qualifier (with IO_Addr_Strobe)
//   IO_Write_Strobe  write qualifier (with IO_Addr_Strobe), wins over read
//   IO_Address       byte address, bits [7:2] decoded
//   IO_Byte_Enable   write byte lanes
//   IO_Write_Data    write data
//   IO_Read_Data     read data, non-zero only while IO_Ready is high
//   IO_Ready         one-cycle completion pulse
//   led              LED register contents
//   dip_sw           asynchronous switch inputs
//   irq              interrupt request
//
// Register map (word offset = IO_Address[7:2]):
//   0x00 LED  0x04 SW  0x08 SCRATCH  0x0C CYCLE  0x10 IRQ_STAT  0x14 IRQ_EN
// ---------------------------------------------------------------------------
module mcs_io_responder #(
    parameter int WAIT_CYCLES = 0,
    parameter int LED_W       = 4,
    parameter int SW_W        = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             IO_Addr_Strobe,
    input  logic             IO_Read_Strobe,
    input  logic             IO_Write_Strobe,
    input  logic [31:0]      IO_Address,
    input  logic [3:0]       IO_Byte_Enable,
    input  logic [31:0]      IO_Write_Data,
    output logic [31:0]      IO_Read_Data,
    output logic             IO_Ready,
    output logic [LED_W-1:0] led,
    input  logic [SW_W-1:0]  dip_sw,
    output logic             irq
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
    localparam bit         HAS_WAIT  = (WAIT_CYCLES > 0);

    localparam logic [5:0] A_LED      = 6'h00;
    localparam logic [5:0] A_SW       = 6'h01;
    localparam logic [5:0] A_SCRATCH  = 6'h02;
    localparam logic [5:0] A_CYCLE    = 6'h03;
    localparam logic [5:0] A_IRQ_STAT = 6'h04;
    localparam logic [5:0] A_IRQ_EN   = 6'h05;

    state_t            state_r;
    state_t            state_nx_s;
    logic [3:0]        wait_cnt_r;
    logic [3:0]        wait_cnt_nx_s;
    logic              accept_s;

    logic [5:0]        addr_r;
    logic [3:0]        be_r;
    logic [31:0]       wdata_r;
    logic              we_r;
    logic              re_r;

    logic [5:0]        txn_addr_s;
    logic              txn_re_s;
    logic              wr_en_s;

    logic [LED_W-1:0]  led_r;
    logic [SW_W-1:0]   sw_meta_r;
    logic [SW_W-1:0]   sw_sync_r;
    logic [31:0]       scratch_r;
    logic [31:0]       cycle_cnt_r;

    logic              irq_stat_nx_s;
    logic              irq_en_s;

    logic [31:0]       rd_mux_s;
    logic [31:0]       rdata_r;
    logic              ready_r;

    logic              unused_addr_s;

    assign unused_addr_s = ^{IO_Address[31:8], IO_Address[1:0]};

    // Next-state logic of the accept/wait/acknowledge sequencer.
    always_comb begin
        state_nx_s    = state_r;
        wait_cnt_nx_s = wait_cnt_r;
        accept_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (IO_Addr_Strobe) begin
                    accept_s = 1'b1;
                    if (HAS_WAIT) begin
                        state_nx_s    = ST_WAIT;
                        wait_cnt_nx_s = WAIT_INIT;
                    end else begin
                        state_nx_s    = ST_ACK;
                        wait_cnt_nx_s = 4'd0;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r <= 4'd1) begin
                    state_nx_s    = ST_ACK;
                    wait_cnt_nx_s = 4'd0;
                end else begin
                    wait_cnt_nx_s = wait_cnt_r - 4'd1;
                end
            end
            ST_ACK: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s    = ST_IDLE;
                wait_cnt_nx_s = 4'd0;
            end
        endcase
    end

    // Sequencer state, wait counter and the latched transaction.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= 4'd0;
            addr_r     <= 6'd0;
            be_r       <= 4'd0;
            wdata_r    <= 32'd0;
            we_r       <= 1'b0;
            re_r       <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            wait_cnt_r <= wait_cnt_nx_s;
            if (accept_s) begin
                addr_r  <= IO_Address[7:2];
                be_r    <= IO_Byte_Enable;
                wdata_r <= IO_Write_Data;
                we_r    <= IO_Write_Strobe;
                re_r    <= IO_Read_Strobe & ~IO_Write_Strobe;
            end
        end
    end

    // Transaction seen by the read path: with no wait states the ACK follows
    // the strobe directly, so the bus inputs are used before they are latched.
    always_comb begin
        if (state_r == ST_IDLE) begin
            txn_addr_s = IO_Address[7:2];
            txn_re_s   = IO_Read_Strobe & ~IO_Write_Strobe;
        end else begin
            txn_addr_s = addr_r;
            txn_re_s   = re_r;
        end
    end

    assign wr_en_s = (state_r == ST_ACK) && we_r;

    // Two-flop synchronizer for the switch inputs.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            sw_meta_r <= '0;
            sw_sync_r <= '0;
        end else begin
            sw_meta_r <= dip_sw;
            sw_sync_r <= sw_meta_r;
        end
    end

    // LED and scratch registers, committed in the ACK cycle of a write.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            led_r     <= '0;
            scratch_r <= 32'd0;
        end else begin
            if (wr_en_s && (addr_r == A_LED) && be_r[0]) begin
                led_r <= wdata_r[LED_W-1:0];
            end
            if (wr_en_s && (addr_r == A_SCRATCH)) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_r[b]) begin
                        scratch_r[8*b +: 8] <= wdata_r[8*b +: 8];
                    end
                end
            end
        end
    end

    // Free-running cycle counter; any write to its offset clears it.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            cycle_cnt_r <= 32'd0;
        end else if (wr_en_s && (addr_r == A_CYCLE)) begin
            cycle_cnt_r <= 32'd0;
        end else begin
            cycle_cnt_r <= cycle_cnt_r + 32'd1;
        end
    end

`ifdef MCS_IO_IRQ_EN
    logic [SW_W-1:0] sw_prev_r;
    logic            sw_change_s;
    logic            irq_stat_r;
    logic            irq_en_r;
    logic            irq_r;

    assign sw_change_s   = |(sw_sync_r ^ sw_prev_r);
    // Writes never land in the cycle before ACK, so only a set can move it.
    assign irq_stat_nx_s = irq_stat_r | sw_change_s;
    assign irq_en_s      = irq_en_r;
    assign irq           = irq_r;

    // Change detect, sticky status (set beats clear), enable and irq flop.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            sw_prev_r  <= '0;
            irq_stat_r <= 1'b0;
            irq_en_r   <= 1'b0;
            irq_r      <= 1'b0;
        end else begin
            sw_prev_r <= sw_sync_r;
            if (sw_change_s) begin
                irq_stat_r <= 1'b1;
            end else if (wr_en_s && (addr_r == A_IRQ_STAT) && be_r[0] && wdata_r[0]) begin
                irq_stat_r <= 1'b0;
            end
            if (wr_en_s && (addr_r == A_IRQ_EN) && be_r[0]) begin
                irq_en_r <= wdata_r[0];
            end
            irq_r <= irq_stat_r & irq_en_r;
        end
    end
`else
    assign irq_stat_nx_s = 1'b0;
    assign irq_en_s      = 1'b0;
    assign irq           = 1'b0;
`endif

    // Read multiplexer. It is sampled on the edge into ACK, so each entry is
    // the value the register will hold during the ACK cycle.
    always_comb begin
        rd_mux_s = 32'd0;
        case (txn_addr_s)
            A_LED:      rd_mux_s = 32'(led_r);
            A_SW:       rd_mux_s = 32'(sw_meta_r);
            A_SCRATCH:  rd_mux_s = scratch_r;
            A_CYCLE:    rd_mux_s = cycle_cnt_r + 32'd1;
            A_IRQ_STAT: rd_mux_s = {31'd0, irq_stat_nx_s};
            A_IRQ_EN:   rd_mux_s = {31'd0, irq_en_s};
            default:    rd_mux_s = 32'd0;
        endcase
    end

    // Registered bus response: ready pulse and read data only in ACK.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            ready_r <= 1'b0;
            rdata_r <= 32'd0;
        end else begin
            ready_r <= (state_nx_s == ST_ACK);
            if ((state_nx_s == ST_ACK) && txn_re_s) begin
                rdata_r <= rd_mux_s;
            end else begin
                rdata_r <= 32'd0;
            end
        end
    end

    assign IO_Ready     = ready_r;
    assign IO_Read_Data = rdata_r;
    assign led          = led_r;

endmodule

// File: tb/tb_mcs_io_responder.sv
// Bench for mcs_io_responder: one instance with no wait states and one with
// three, sharing the bus inputs. Each access pushes the expected completion
// cycle and read data per instance; negedge monitors pop and compare.
module tb_mcs_io_responder;

`ifdef MCS_IO_IRQ_EN
    localparam logic [31:0] IRQ_ON = 32'd1;
`else
    localparam logic [31:0] IRQ_ON = 32'd0;
`endif

    typedef struct {
        int          cyc;
        logic [31:0] data;
        bit          chk;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        as, rs, ws;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic [3:0]  dip;
    logic [31:0] rd0, rd3;
    logic        rdy0, rdy3;
    logic [3:0]  led0, led3;
    logic        irq0, irq3;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t q0[$];
    exp_t q3[$];

    mcs_io_responder #(.WAIT_CYCLES(0), .LED_W(4), .SW_W(4)) u_dut0 (
        .Clk(clk), .Reset(rst_n), .IO_Addr_Strobe(as), .IO_Read_Strobe(rs),
        .IO_Write_Strobe(ws), .IO_Address(addr), .IO_Byte_Enable(be),
        .IO_Write_Data(wdata), .IO_Read_Data(rd0), .IO_Ready(rdy0),
        .led(led0), .dip_sw(dip), .irq(irq0)
    );

    mcs_io_responder #(.WAIT_CYCLES(3), .LED_W(4), .SW_W(4)) u_dut3 (
        .Clk(clk), .Reset(rst_n), .IO_Addr_Strobe(as), .IO_Read_Strobe(rs),
        .IO_Write_Strobe(ws), .IO_Address(addr), .IO_Byte_Enable(be),
        .IO_Write_Data(wdata), .IO_Read_Data(rd3), .IO_Ready(rdy3),
        .led(led3), .dip_sw(dip), .irq(irq3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: actual=%h expected=%h (cycle %0d)", nm, id, act, exp, cyc);
        end
    endtask

    task automatic mon(input int id, input logic rdy, input logic [31:0] d);
        exp_t e;
        int   n;
        n = (id == 0) ? q0.size() : q3.size();
        if (n > 0) begin
            if (id == 0) e = q0[0];
            else         e = q3[0];
        end
        if (rdy) begin
            if (n == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ready dut%0d: actual=1 expected=0 (cycle %0d)", id, cyc);
            end else begin
                if (id == 0) void'(q0.pop_front());
                else         void'(q3.pop_front());
                check("ready_cycle", id, cyc, e.cyc);
                if (e.chk) check("read_data", id, d, e.data);
            end
        end else begin
            check("idle_data", id, d, 32'd0);
            if (n > 0 && cyc > e.cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL missing_ready dut%0d: actual=0 expected=1 (cycle %0d)", id, e.cyc);
                if (id == 0) void'(q0.pop_front());
                else         void'(q3.pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, rdy0, rd0);
        mon(3, rdy3, rd3);
    end

    task automatic drain();
        for (int k = 0; k < 20 && (q0.size() != 0 || q3.size() != 0); k++) @(negedge clk);
    endtask

    // One bus access starting no earlier than cycle 'at'; waits for both acks.
    task automatic access(input int at, input logic w, input logic r, input logic [31:0] a,
                          input logic [3:0] b, input logic [31:0] wd,
                          input logic [31:0] e0, input logic [31:0] e3, input bit c3,
                          output int s);
        exp_t x;
        @(negedge clk);
        while (cyc < at) @(negedge clk);
        s = cyc;
        as = 1'b1; ws = w; rs = r; addr = a; be = b; wdata = wd;
        x.cyc = s + 1; x.data = e0; x.chk = 1'b1; q0.push_back(x);
        x.cyc = s + 4; x.data = e3; x.chk = c3;   q3.push_back(x);
        @(negedge clk);
        as = 1'b0; ws = 1'b0; rs = 1'b0;
        drain();
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e);
        int s;
        access(0, 1'b0, 1'b1, a, 4'hF, 32'd0, e, e, 1'b1, s);
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
        int s;
        access(0, 1'b1, 1'b0, a, b, d, 32'd0, 32'd0, 1'b1, s);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   s, sclr;
        exp_t x;
        rst_n = 1'b0; as = 1'b0; rs = 1'b0; ws = 1'b0;
        addr = 32'd0; be = 4'd0; wdata = 32'd0; dip = 4'd0;
        repeat (3) @(negedge clk);
        check("rst_led", 0, 32'(led0), 32'd0);
        check("rst_led", 3, 32'(led3), 32'd0);
        check("rst_irq", 0, 32'(irq0), 32'd0);
        check("rst_irq", 3, 32'(irq3), 32'd0);
        rst_n = 1'b1;

        // LED write and read back; a write without BE[0] is ignored
        wr(32'h00, 4'hF, 32'h5);
        check("led_out", 0, 32'(led0), 32'h5);
        check("led_out", 3, 32'(led3), 32'h5);
        rd(32'h00, 32'h5);
        wr(32'h00, 4'hE, 32'hA);
        rd(32'h00, 32'h5);

        // Scratch byte lanes, read+write treated as write, no-qualifier access
        wr(32'h08, 4'b0101, 32'hA1B2C3D4);
        rd(32'h08, 32'h00B200D4);
        access(0, 1'b1, 1'b1, 32'h08, 4'hF, 32'h11223344, 32'd0, 32'd0, 1'b1, s);
        rd(32'h08, 32'h11223344);
        access(0, 1'b0, 1'b0, 32'h08, 4'hF, 32'hDEADBEEF, 32'd0, 32'd0, 1'b1, s);
        rd(32'h08, 32'h11223344);

        // Synchronized switches and an unmapped offset
        dip = 4'b1001;
        repeat (4) @(negedge clk);
        rd(32'h04, 32'h9);
        rd(32'h3C, 32'h0);
        wr(32'h3C, 4'hF, 32'hFFFFFFFF);
        rd(32'h3C, 32'h0);

        // Counter clear and two reads 10 cycles apart (r - s - 1 on both)
        access(0, 1'b1, 1'b0, 32'h0C, 4'h2, 32'h0, 32'd0, 32'd0, 1'b1, sclr);
        access(sclr + 8, 1'b0, 1'b1, 32'h0C, 4'hF, 32'd0, 32'd7, 32'd7, 1'b1, s);
        access(sclr + 18, 1'b0, 1'b1, 32'h0C, 4'hF, 32'd0, 32'd17, 32'd17, 1'b1, s);

        // Counter wrap: dut0 counter held at all-ones while the read is accepted
        @(negedge clk);
        s = cyc;
        force u_dut0.cycle_cnt_r = 32'hFFFFFFFF;
        as = 1'b1; rs = 1'b1; addr = 32'h0C; be = 4'hF;
        x.cyc = s + 1; x.data = 32'h0; x.chk = 1'b1; q0.push_back(x);
        x.cyc = s + 4; x.data = 32'h0; x.chk = 1'b0; q3.push_back(x);
        @(negedge clk);
        release u_dut0.cycle_cnt_r;
        as = 1'b0; rs = 1'b0;
        drain();

        // Interrupt path
        wr(32'h10, 4'h1, 32'h1);
        wr(32'h14, 4'h1, 32'h1);
        repeat (3) @(negedge clk);
        check("irq_quiet", 0, 32'(irq0), 32'd0);
        check("irq_quiet", 3, 32'(irq3), 32'd0);
        rd(32'h14, IRQ_ON);
        dip[2] = ~dip[2];
        repeat (6) @(negedge clk);
        check("irq_set", 0, 32'(irq0), IRQ_ON);
        check("irq_set", 3, 32'(irq3), IRQ_ON);
        rd(32'h10, IRQ_ON);
        wr(32'h10, 4'h1, 32'h1);
        repeat (3) @(negedge clk);
        check("irq_clr", 0, 32'(irq0), 32'd0);
        check("irq_clr", 3, 32'(irq3), 32'd0);
        rd(32'h10, 32'h0);

        // Strobe while busy is ignored; reset while dut3 waits kills its ack
        @(negedge clk);
        s = cyc;
        as = 1'b1; ws = 1'b1; addr = 32'h00; be = 4'hF; wdata = 32'h3;
        x.cyc = s + 1; x.data = 32'h0; x.chk = 1'b1; q0.push_back(x);
        @(negedge clk);
        wdata = 32'hC;
        @(negedge clk);
        as = 1'b0; ws = 1'b0;
        check("busy_ignored", 0, 32'(led0), 32'h3);
        check("busy_ignored", 3, 32'(led3), 32'h5);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("wait_rst_led", 0, 32'(led0), 32'd0);
        check("wait_rst_led", 3, 32'(led3), 32'd0);
        repeat (8) @(negedge clk);
        check("wait_rst_irq", 3, 32'(irq3), 32'd0);
        rd(32'h08, 32'h0);
        rd(32'h14, 32'h0);
        wr(32'h00, 4'h1, 32'h6);
        check("post_rst_led", 0, 32'(led0), 32'h6);
        check("post_rst_led", 3, 32'(led3), 32'h6);
        repeat (4) @(negedge clk);

        check("queue_empty", 0, 32'(q0.size()), 32'd0);
        check("queue_empty", 3, 32'(q3.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
